prod_accum: RTL and testbench



---
 rtl/prod_accum_if.sv | 24 ++
 rtl/prod_accum.sv | 100 ++++++++++
 tb/tb_prod_accum.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prod_accum_if.sv
// prod_accum_if: product input and result output handshakes for prod_accum.
// master drives products and consumes results; slave is the accumulator.
interface prod_accum_if #(
  parameter int unsigned ACC_W = 12
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output clear, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  clear, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/prod_accum.sv
// prod_accum: sums LEN consecutive 8-bit products into one ACC_W-bit result
// and holds it on a registered valid/ready output until consumed.
// Optional macro PROD_ACCUM_SAT_EN: on overflow the accumulator clamps to
// all-ones for the rest of the result; otherwise it wraps. out_ovf flags
// the overflow in both builds.
module prod_accum #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 12
) (
  input logic         clk,
  input logic         rst,
  prod_accum_if.slave bus
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [SUM_W-1:0] sum_c;
  logic [ACC_W-1:0] acc_nxt_c;
  logic             ovf_nxt_c;
  logic             accept_c;
  logic             last_c;

  // Next accumulator value and sticky overflow for an accepted product
  always_comb begin
    sum_c     = SUM_W'(acc) + SUM_W'(bus.in_prod);
    ovf_nxt_c = ovf | sum_c[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
    acc_nxt_c = ovf_nxt_c ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
    acc_nxt_c = sum_c[ACC_W-1:0];
`endif
    accept_c  = bus.in_valid & bus.in_ready;
    last_c    = (cnt == CNT_W'(LEN - 1));
  end

  // Accumulate/hold state machine with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ACCUM;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_ovf   <= 1'b0;
    end else if (bus.clear) begin
      state         <= ACCUM;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept_c) begin
            acc <= acc_nxt_c;
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf_nxt_c;
            if (last_c) begin
              state         <= HOLD;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              bus.out_sum   <= acc_nxt_c;
              bus.out_ovf   <= ovf_nxt_c;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state         <= ACCUM;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed checks of prod_accum (LEN=4/ACC_W=12 main instance,
// LEN=2/ACC_W=8 instance for overflow). Honors PROD_ACCUM_SAT_EN.
module tb_prod_accum;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  prod_accum_if #(.ACC_W(12)) b ();
  prod_accum_if #(.ACC_W(8))  o ();

  prod_accum #(.LEN(4), .ACC_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  prod_accum #(.LEN(2), .ACC_W(8)) dut_ovf (
    .clk (clk),
    .rst (rst),
    .bus (o.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product on the main instance and wait (bounded) for acceptance
  task automatic put(input logic [7:0] p);
    int n;
    n = 0;
    b.in_valid = 1'b1;
    b.in_prod  = p;
    while (!b.in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (b.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL put_ready got=%0b exp=1", b.in_ready);
    end
    tick();
    b.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b.clear = 1'b0; b.in_valid = 1'b0; b.in_prod = 8'd0; b.out_ready = 1'b0;
    o.clear = 1'b0; o.in_valid = 1'b0; o.in_prod = 8'd0; o.out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (b.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", b.in_ready); end
    checks++;
    if (b.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", b.out_valid); end
    checks++;
    if (b.out_sum !== 12'd0) begin failures++; $display("FAIL reset_out_sum got=%0d exp=0", b.out_sum); end
    checks++;
    if (b.out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%0b exp=0", b.out_ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    b.out_ready = 1'b1;
    b.in_valid  = 1'b1;
    b.in_prod   = 8'd225;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (b.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", b.out_valid); end
    tick();
    b.in_valid = 1'b0;
    checks++;
    if (b.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", b.out_valid); end
    checks++;
    if (b.out_sum !== 12'd900) begin failures++; $display("FAIL basic_sum got=%0d exp=900", b.out_sum); end
    checks++;
    if (b.out_ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%0b exp=0", b.out_ovf); end
    tick();
    checks++;
    if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_consume got=valid%0b/ready%0b exp=valid0/ready1", b.out_valid, b.in_ready);
    end
  endtask

  task automatic test_backpressure();
    b.out_ready = 1'b0;
    put(8'd10); put(8'd20); put(8'd30); put(8'd40);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (b.out_sum !== 12'd100 || b.out_valid !== 1'b1 || b.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=sum%0d/valid%0b/ready%0b exp=sum100/valid1/ready0",
                 i, b.out_sum, b.out_valid, b.in_ready);
      end
      tick();
    end
    b.out_ready = 1'b1;
    put(8'd5);
    put(8'd1); put(8'd1); put(8'd1);
    checks++;
    if (b.out_sum !== 12'd8 || b.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_next_sum got=sum%0d/valid%0b exp=sum8/valid1", b.out_sum, b.out_valid);
    end
    tick();
  endtask

  task automatic test_gaps();
    b.out_ready = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      put(8'(p));
      if (p < 4) begin
        tick();
        tick();
      end
      if (p == 3) begin
        checks++;
        if (b.out_valid !== 1'b0) begin failures++; $display("FAIL gaps_early_valid got=%0b exp=0", b.out_valid); end
      end
    end
    checks++;
    if (b.out_sum !== 12'd10 || b.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL gaps_sum got=sum%0d/valid%0b exp=sum10/valid1", b.out_sum, b.out_valid);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_sum;
`ifdef PROD_ACCUM_SAT_EN
    exp_sum = 8'd255;
`else
    exp_sum = 8'd44;
`endif
    o.out_ready = 1'b1;
    o.in_valid  = 1'b1;
    o.in_prod   = 8'd200;
    tick();
    o.in_prod   = 8'd100;
    tick();
    o.in_valid  = 1'b0;
    checks++;
    if (o.out_sum !== exp_sum || o.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sum got=sum%0d/valid%0b exp=sum%0d/valid1", o.out_sum, o.out_valid, exp_sum);
    end
    checks++;
    if (o.out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", o.out_ovf); end
    tick();
    o.in_valid = 1'b1;
    o.in_prod  = 8'd1;
    tick();
    o.in_prod  = 8'd2;
    tick();
    o.in_valid = 1'b0;
    checks++;
    if (o.out_sum !== 8'd3 || o.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_next got=sum%0d/ovf%0b exp=sum3/ovf0", o.out_sum, o.out_ovf);
    end
    tick();
  endtask

  task automatic test_abort_reset();
    b.out_ready = 1'b0;
    put(8'd50); put(8'd60);
    b.clear = 1'b1;
    tick();
    b.clear = 1'b0;
    put(8'd1); put(8'd1); put(8'd1); put(8'd1);
    checks++;
    if (b.out_sum !== 12'd4 || b.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_sum got=sum%0d/valid%0b exp=sum4/valid1", b.out_sum, b.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (b.out_valid !== 1'b0 || b.out_sum !== 12'd0 || b.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got=valid%0b/sum%0d/ready%0b exp=valid0/sum0/ready1",
               b.out_valid, b.out_sum, b.in_ready);
    end
    tick();
    rst = 1'b0;
    put(8'd7); put(8'd7); put(8'd7); put(8'd7);
    checks++;
    if (b.out_sum !== 12'd28) begin failures++; $display("FAIL hold_sum got=%0d exp=28", b.out_sum); end
    // clear in HOLD wins over a same-cycle consume
    b.clear     = 1'b1;
    b.out_ready = 1'b1;
    b.in_valid  = 1'b1;
    b.in_prod   = 8'd9;
    tick();
    b.clear    = 1'b0;
    b.in_valid = 1'b0;
    checks++;
    if (b.out_valid !== 1'b0 || b.out_sum !== 12'd0 || b.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_hold got=valid%0b/sum%0d/ready%0b exp=valid0/sum0/ready1",
               b.out_valid, b.out_sum, b.in_ready);
    end
    put(8'd2); put(8'd2); put(8'd2); put(8'd2);
    checks++;
    if (b.out_sum !== 12'd8 || b.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_restart got=sum%0d/valid%0b exp=sum8/valid1", b.out_sum, b.out_valid);
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_overflow();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
